// File: rtl/async_event_sync.sv
// async_event_sync
// Multi-channel conditioner for asynchronous inputs (pads, external IRQs,
// status lines). Each channel runs independently through:
//   synchroniser chain -> glitch filter -> edge detector -> pulse stretcher
//   plus a sticky pending flag with overflow detection.
//
// Ports
//   clk          single clock
//   rstn         synchronous active-low reset, sampled on rising clk
//   async_in     [CH]        asynchronous inputs, one bit per channel
//   mode         [2*CH]      per-channel edge mode: 00 rise, 01 fall, 10 both, 11 off
//   filt_len     [FILT_W]    glitch filter length, shared by all channels
//   stretch_len  [STRETCH_W] pulse stretch length, shared by all channels
//   clr          [CH]        per-channel clear of pending and ovf
//   level_out    [CH]        filtered synchronised level
//   pulse_out    [CH]        stretched event pulse (stretch_len+1 cycles)
//   pending      [CH]        sticky event flag
//   ovf          [CH]        sticky flag: event arrived while pending was set
module async_event_sync #(
  parameter int              CH          = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [CH-1:0]   DEFAULT_VAL = {CH{1'b0}},
  parameter int              FILT_W      = 4,
  parameter int              STRETCH_W   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CH-1:0]        async_in,
  input  logic [2*CH-1:0]      mode,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic [CH-1:0]        clr,
  output logic [CH-1:0]        level_out,
  output logic [CH-1:0]        pulse_out,
  output logic [CH-1:0]        pending,
  output logic [CH-1:0]        ovf
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CH-1:0]                  level_q, level_d;
  logic [CH-1:0][FILT_W-1:0]      cnt_q, cnt_d;
  logic [CH-1:0]                  pulse_q, pulse_d;
  logic [CH-1:0][STRETCH_W-1:0]   scnt_q, scnt_d;
  logic [CH-1:0]                  pending_q, pending_d;
  logic [CH-1:0]                  ovf_q, ovf_d;

  logic [CH-1:0]                  sync_out_s;
  logic [CH-1:0]                  commit_s;
  logic [CH-1:0]                  event_s;

  // Synchroniser shift: stage 0 samples the pin, the last stage feeds the filter.
  always_comb begin
    sync_d     = sync_q;
    sync_out_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      sync_d[i]     = {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      sync_out_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Glitch filter: commit a new level only after filt_len+1 consecutive
  // differing samples. Equality (not >=) is deliberate so a shortened
  // filt_len lets a running count wrap instead of committing early.
  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    commit_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (sync_out_s[i] == level_q[i]) begin
        cnt_d[i] = {FILT_W{1'b0}};
      end else if (cnt_q[i] == filt_len) begin
        level_d[i]  = sync_out_s[i];
        cnt_d[i]    = {FILT_W{1'b0}};
        commit_s[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  // Edge detector: a commit is an event when its direction matches the mode.
  // The committed direction is simply the new level (sync_out at commit time).
  always_comb begin
    event_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        MODE_RISE: event_s[i] = commit_s[i] & sync_out_s[i];
        MODE_FALL: event_s[i] = commit_s[i] & ~sync_out_s[i];
        MODE_BOTH: event_s[i] = commit_s[i];
        default:   event_s[i] = 1'b0;
      endcase
    end
  end

  // Pulse stretcher: an event (re)loads the down-counter, so a retrigger
  // extends the pulse seamlessly.
  always_comb begin
    pulse_d = pulse_q;
    scnt_d  = scnt_q;
    for (int i = 0; i < CH; i++) begin
      if (event_s[i]) begin
        pulse_d[i] = 1'b1;
        scnt_d[i]  = stretch_len;
      end else if (pulse_q[i]) begin
        if (scnt_q[i] == {STRETCH_W{1'b0}}) begin
          pulse_d[i] = 1'b0;
        end else begin
          scnt_d[i] = scnt_q[i] - STRETCH_W'(1);
        end
      end else begin
        pulse_d[i] = 1'b0;
      end
    end
  end

  // Pending/overflow: a simultaneous clr consumes the previous event, so the
  // new event sets pending but does not count as an overflow.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < CH; i++) begin
      if (event_s[i]) begin
        pending_d[i] = 1'b1;
        if (clr[i]) begin
          ovf_d[i] = 1'b0;
        end else if (pending_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          ovf_d[i] = ovf_q[i];
        end
      end else if (clr[i]) begin
        pending_d[i] = 1'b0;
        ovf_d[i]     = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{DEFAULT_VAL[i]}};
        cnt_q[i]  <= {FILT_W{1'b0}};
        scnt_q[i] <= {STRETCH_W{1'b0}};
      end
      level_q   <= DEFAULT_VAL;
      pulse_q   <= {CH{1'b0}};
      pending_q <= {CH{1'b0}};
      ovf_q     <= {CH{1'b0}};
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_async_event_sync.sv
module tb_async_event_sync;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam logic [CH-1:0] DEF = 4'b0000;

  logic          clk;
  logic          rstn;
  logic [CH-1:0] async_in;
  logic [7:0]    mode;
  logic [3:0]    filt_len;
  logic [3:0]    stretch_len;
  logic [CH-1:0] clr;
  logic [CH-1:0] level_out, pulse_out, pending, ovf;

  async_event_sync #(.CH(CH), .SYNC_STAGES(S), .DEFAULT_VAL(DEF),
                     .FILT_W(4), .STRETCH_W(4)) dut (
    .clk(clk), .rstn(rstn), .async_in(async_in), .mode(mode),
    .filt_len(filt_len), .stretch_len(stretch_len), .clr(clr),
    .level_out(level_out), .pulse_out(pulse_out), .pending(pending), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input seen by the filter at edge k is the input sampled at edge k-S.
  logic [CH-1:0] hist[$];
  int            streak[CH];
  longint        pulse_until[CH];
  longint        edge_n = 0;
  logic [CH-1:0] m_lvl, m_pend, m_ovf;

  function automatic logic [CH-1:0] m_pulse();
    logic [CH-1:0] p;
    for (int i = 0; i < CH; i++) p[i] = (edge_n < pulse_until[i]);
    return p;
  endfunction

  initial begin
    logic [CH-1:0] sv;
    logic [1:0]    md;
    bit            ev;
    for (int k = 0; k < S; k++) hist.push_back(DEF);
    m_lvl = DEF; m_pend = '0; m_ovf = '0;
    for (int i = 0; i < CH; i++) begin streak[i] = 0; pulse_until[i] = 0; end
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rstn) begin
        hist.delete();
        for (int k = 0; k < S; k++) hist.push_back(DEF);
        m_lvl = DEF; m_pend = '0; m_ovf = '0;
        for (int i = 0; i < CH; i++) begin streak[i] = 0; pulse_until[i] = 0; end
      end else begin
        sv = hist.pop_front();
        hist.push_back(async_in);
        for (int i = 0; i < CH; i++) begin
          ev = 1'b0;
          if (sv[i] == m_lvl[i]) streak[i] = 0;
          else begin
            streak[i]++;
            if (streak[i] >= int'(filt_len) + 1) begin
              m_lvl[i] = sv[i];
              streak[i] = 0;
              md = mode[2*i +: 2];
              ev = (md == 2'b10) || (md == 2'b00 && sv[i]) || (md == 2'b01 && !sv[i]);
            end
          end
          if (ev) begin
            pulse_until[i] = edge_n + longint'(stretch_len) + 1;
            if (m_pend[i] && !clr[i]) m_ovf[i] = 1'b1;
            else if (clr[i])          m_ovf[i] = 1'b0;
            m_pend[i] = 1'b1;
          end else if (clr[i]) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("level_out", level_out, m_lvl);
        chk("pulse_out", pulse_out, m_pulse());
        chk("pending",   pending,   m_pend);
        chk("ovf",       ovf,       m_ovf);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int hi_lvl[CH], hi_pulse[CH], rise_pulse[CH];
  logic [CH-1:0] prev_pulse;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) begin hi_lvl[i] = 0; hi_pulse[i] = 0; rise_pulse[i] = 0; end
    prev_pulse = pulse_out;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < CH; i++) begin
        if (level_out[i]) hi_lvl[i]++;
        if (pulse_out[i]) hi_pulse[i]++;
        if (pulse_out[i] && !prev_pulse[i]) rise_pulse[i]++;
      end
      prev_pulse = pulse_out;
    end
  endtask

  initial begin
    logic [CH-1:0] cap_l, cap_p, cap_pe, cap_o;
    int hi, rises;
    logic prev;

    rstn = 1'b0; async_in = 4'b0000; mode = 8'b0000_0000;
    filt_len = 4'd3; stretch_len = 4'd2; clr = 4'b0000;
    step();
    chk_en = 1'b1;
    step();
    chk("reset level", level_out, 4'b0000);
    chk("reset pulse", pulse_out, 4'b0000);
    chk("reset pend",  pending,   4'b0000);
    chk("reset ovf",   ovf,       4'b0000);
    rstn = 1'b1;
    run(4);

    // 1: rise event on ch0, latency S + filt_len + 1 = 6 edges
    async_in[0] = 1'b1;
    run(5);
    chk("t1 level before", level_out[0], 1'b0);
    run(1);
    chk("t1 level at 6th", level_out[0], 1'b1);
    chk("t1 pulse start", pulse_out[0], 1'b1);
    run(2);
    chk("t1 pulse 3rd", pulse_out[0], 1'b1);
    run(1);
    chk("t1 pulse end", pulse_out[0], 1'b0);
    chk("t1 pend", pending[0], 1'b1);
    chk("t1 ovf", ovf[0], 1'b0);
    chk("t1 quiet", {level_out[3:1], pulse_out[3:1], pending[3:1]}, 9'd0);

    // 2: glitch rejection on ch1
    clear_counts();
    async_in[1] = 1'b1; run(3); async_in[1] = 1'b0; run(15);
    chk("t2 glitch lvl", hi_lvl[1], 0);
    chk("t2 glitch pulse", rise_pulse[1], 0);
    chk("t2 glitch pend", pending[1], 1'b0);
    clear_counts();
    async_in[1] = 1'b1; run(4); async_in[1] = 1'b0; run(15);
    chk("t2 4cyc lvl", hi_lvl[1], 4);
    chk("t2 4cyc pulse", rise_pulse[1], 1);

    // 3: modes: ch0 off, ch2 both, ch3 fall
    clr = 4'b1111; step(); clr = 4'b0000;
    mode = 8'b01_10_00_11;
    async_in[0] = 1'b0; run(10);
    clear_counts();
    async_in[0] = 1'b1; async_in[2] = 1'b1; async_in[3] = 1'b1;
    run(12);
    chk("t3 ch0 tracks hi", level_out[0], 1'b1);
    async_in[0] = 1'b0; async_in[2] = 1'b0; async_in[3] = 1'b0;
    run(12);
    chk("t3 ch0 tracks lo", level_out[0], 1'b0);
    chk("t3 ch0 hi cycles", hi_lvl[0], 12);
    chk("t3 ch0 pulses", rise_pulse[0], 0);
    chk("t3 ch0 pend", pending[0], 1'b0);
    chk("t3 ch2 pulses", rise_pulse[2], 2);
    chk("t3 ch2 ovf", ovf[2], 1'b1);
    chk("t3 ch3 pulses", rise_pulse[3], 1);
    chk("t3 ch3 pend/ovf", {pending[3], ovf[3]}, 2'b10);

    // 4: pending/ovf on ch0
    mode = 8'b01_10_00_00;
    clr = 4'b1111; step(); clr = 4'b0000;
    async_in[0] = 1'b1; run(10);
    chk("t4 first pend/ovf", {pending[0], ovf[0]}, 2'b10);
    async_in[0] = 1'b0; run(10);
    async_in[0] = 1'b1; run(10);
    chk("t4 second pend/ovf", {pending[0], ovf[0]}, 2'b11);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("t4 clr pend/ovf", {pending[0], ovf[0]}, 2'b00);
    async_in[0] = 1'b0; run(10);
    async_in[0] = 1'b1; run(10);
    async_in[0] = 1'b0; run(10);
    chk("t4 re-pend", pending[0], 1'b1);
    async_in[0] = 1'b1; run(5);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("t4 clr+event level", level_out[0], 1'b1);
    chk("t4 clr+event pend/ovf", {pending[0], ovf[0]}, 2'b10);
    run(5);

    // 5: retrigger on ch2 (mode both), toggle every 3 cycles, 5 toggles
    filt_len = 4'd0; stretch_len = 4'd7;
    run(2);
    hi = 0; rises = 0; prev = pulse_out[2];
    for (int j = 0; j < 40; j++) begin
      if (j % 3 == 0 && j < 15) async_in[2] = ~async_in[2];
      step();
      if (pulse_out[2]) hi++;
      if (pulse_out[2] && !prev) rises++;
      prev = pulse_out[2];
    end
    chk("t5 high cycles", hi, 20);
    chk("t5 continuous", rises, 1);

    // 6: reset mid-pulse with filter running on ch1
    filt_len = 4'd3; stretch_len = 4'd7;
    mode = 8'b01_10_00_00;
    run(3);
    async_in[1] = 1'b1; run(6);
    chk("t6 pulse active", pulse_out[1], 1'b1);
    async_in[1] = 1'b0; run(3);
    cap_l = level_out; cap_p = pulse_out; cap_pe = pending; cap_o = ovf;
    rstn = 1'b0; async_in = DEF;
    #1;
    chk("t6 no async lvl", level_out, cap_l);
    chk("t6 no async pulse", pulse_out, cap_p);
    chk("t6 no async pend/ovf", {pending, ovf}, {cap_pe, cap_o});
    step();
    chk("t6 rst level", level_out, DEF);
    chk("t6 rst pulse", pulse_out, 4'b0000);
    chk("t6 rst pend/ovf", {pending, ovf}, 8'h00);
    rstn = 1'b1;
    clear_counts();
    run(12);
    chk("t6 no event pulses", rise_pulse[0] + rise_pulse[1] + rise_pulse[2] + rise_pulse[3], 0);
    chk("t6 no event pend", pending, 4'b0000);
    chk("t6 level default", level_out, DEF);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
